// File: rtl/amf_pkg.sv
// rtl/amf_pkg.sv - shared constants, window type and noise test for the adaptive mean filter
package amf_pkg;

    localparam int DW_DEF = 8;
    localparam int SUM_W  = DW_DEF + 3;
    localparam int HV_W   = DW_DEF + 2;
    localparam int CNT_W  = 4;
    localparam logic [DW_DEF-1:0] MAXV = {DW_DEF{1'b1}};

    typedef logic [DW_DEF-1:0] window_t [3][3];

    // Width is passed explicitly so the top can be built for any pixel width.
    function automatic logic is_noisy(input logic [31:0] p, input int unsigned dw);
        logic [31:0] maxv;
        maxv = (dw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << dw) - 32'd1);
        return (p == 32'd0) || (p == maxv);
    endfunction

endpackage

// File: rtl/amf_div8.sv
// rtl/amf_div8.sv - combinational exact floor(s/t) for a 1..8 divisor
module amf_div8 #(
    parameter int DW = 8
) (
    input  logic [DW+2:0] s,
    input  logic [3:0]    t,
    output logic [DW-1:0] q
);

    logic [DW+2:0] quo;
    logic [3:0]    rem;

    // Restoring division; the remainder stays below t (<= 8), so 4 bits suffice.
    always_comb begin
        rem = '0;
        quo = '0;
        for (int i = DW + 2; i >= 0; i--) begin
            rem = {rem[2:0], s[i]};
            if (rem >= t) begin
                rem    = rem - t;
                quo[i] = 1'b1;
            end
        end
        q = (|quo[DW+2:DW]) ? {DW{1'b1}} : quo[DW-1:0];
    end

endmodule

// File: rtl/adaptive_mean_stream.sv
// rtl/adaptive_mean_stream.sv - streaming 3x3 adaptive mean filter; AMF_CENTER_PASS_EN keeps clean centres
module adaptive_mean_stream
    import amf_pkg::*;
#(
    parameter int DW    = 8,
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last
);

    localparam int SW = DW + 3;
    localparam int HW = DW + 2;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    logic          en;
    logic          acc;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    assign en      = !m_valid || m_ready;
    assign s_ready = en;
    assign acc     = s_valid && en;

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (acc) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    logic [DW-1:0] lb1 [IMG_W];
    logic [DW-1:0] lb2 [IMG_W];
    logic [DW-1:0] lb1_rd;
    logic [DW-1:0] lb2_rd;
    logic [DW-1:0] win  [3][3];
    logic [DW-1:0] nwin [3][3];

    assign lb1_rd = lb1[col];
    assign lb2_rd = lb2[col];

    // Stage 1 works on the window as it will be after this accept, saving a cycle.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            nwin[r][0] = win[r][1];
            nwin[r][1] = win[r][2];
        end
        nwin[0][2] = lb2_rd;
        nwin[1][2] = lb1_rd;
        nwin[2][2] = s_data;
    end

    always_ff @(posedge clk) begin
        if (acc && !rst) begin
            lb1[col] <= s_data;
            lb2[col] <= lb1_rd;
            win      <= nwin;
        end
    end

    logic [SW-1:0]    sum_c;
    logic [CNT_W-1:0] cnt_c;
    logic [HW-1:0]    hv_c;
    logic             win_ok;
    logic             win_last;

    always_comb begin
        sum_c = '0;
        cnt_c = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (!(r == 1 && c == 1) && !is_noisy(32'(nwin[r][c]), DW)) begin
                    sum_c = sum_c + SW'(nwin[r][c]);
                    cnt_c = cnt_c + CNT_W'(1);
                end
            end
        end
        hv_c = HW'(nwin[0][1]) + HW'(nwin[1][0]) + HW'(nwin[1][2]) + HW'(nwin[2][1]);
    end

    assign win_ok   = (row >= 2) && (col >= 2);
    assign win_last = (row == ROW_MAX) && (col == COL_MAX);

    logic             s1_valid;
    logic             s1_last;
    logic [SW-1:0]    s1_sum;
    logic [CNT_W-1:0] s1_cnt;
    logic [HW-1:0]    s1_hv;
`ifdef AMF_CENTER_PASS_EN
    logic [DW-1:0]    s1_ctr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_sum   <= '0;
            s1_cnt   <= '0;
            s1_hv    <= '0;
`ifdef AMF_CENTER_PASS_EN
            s1_ctr   <= '0;
`endif
        end else if (en) begin
            s1_valid <= acc && win_ok;
            s1_last  <= acc && win_ok && win_last;
            s1_sum   <= sum_c;
            s1_cnt   <= cnt_c;
            s1_hv    <= hv_c;
`ifdef AMF_CENTER_PASS_EN
            s1_ctr   <= nwin[1][1];
`endif
        end
    end

    logic [DW-1:0] div_q;
    logic [DW-1:0] mean_c;

    amf_div8 #(.DW(DW)) u_div (
        .s (s1_sum),
        .t (s1_cnt),
        .q (div_q)
    );

    // With no clean neighbour, fall back to the four edge neighbours.
    always_comb begin
        mean_c = (s1_cnt == '0) ? s1_hv[HW-1:2] : div_q;
`ifdef AMF_CENTER_PASS_EN
        if (!is_noisy(32'(s1_ctr), DW)) mean_c = s1_ctr;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (en) begin
            m_valid <= s1_valid;
            m_data  <= mean_c;
            m_last  <= s1_last;
        end
    end

endmodule

// File: doc/adaptive_mean_stream.md
# adaptive_mean_stream

Streaming, parametrised successor to the 8-neighbour adaptive mean filter. It accepts a raster-order pixel stream over a valid/ready handshake and builds the 3x3 window internally from two line buffers. Salt-and-pepper pixels (value 0 or all-ones) are excluded from the neighbour mean. If all eight neighbours are noisy, the output falls back to the mean of the four edge neighbours. The block sits between the pixel source and the downstream frame sink, and outputs only interior pixels.

## Interface
- DW, 8, pixel width in bits
- IMG_W, 16, frame width in pixels (≥3)
- IMG_H, 16, frame height in pixels (≥3)

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  input pixel valid
- s_ready  out  1  block can accept input
- s_data  in  DW  input pixel, raster order, frame starts at (0,0)
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream accepts output
- m_data  out  DW  filtered interior pixel
- m_last  out  1  high with the final interior pixel of a frame

## Operation
- Transfer occurs when valid && ready on the same edge, on either port.
- Pixel counters: col runs 0..IMG_W-1; row runs 0..IMG_H-1. They advance only on an accepted input. col wraps to 0 and increments row; row wraps to 0 and starts a new frame. There is no frame marker on input.
- Line buffers: two DW x IMG_W memories holding rows r-1 and r-2, read and written at index col on each accept. Contents are not reset.
- Window: 3x3 register array, shifted left on each accept. The new column is {lb2[col], lb1[col], s_data}.
- Window naming: P1..P9 in raster order; P5 is the centre.
- A window is valid when the accepted pixel has row≥2 and col≥2. Its centre is then pixel (row-1, col-1).
- Noisy(p) = (p == 0) || (p == 2^DW-1).
- Stage 1 (registered):
  - S = sum of non-noisy neighbours among P1..P4, P6..P9; width DW+3.
  - T = count of non-noisy neighbours, 0..8; 4 bits.
  - H = P2+P4+P6+P8; width DW+2.
  - P5 and the last flag are also registered.
- Stage 2 (registered into m_data):
  - T==0 -> H>>2.
  - Otherwise floor(S/T), exact, with no rounding.
  - The result always fits DW.
- m_last = window centre is (IMG_H-2, IMG_W-2).
- Outputs per frame: (IMG_W-2)*(IMG_H-2). Border pixels are consumed but never output.

## Timing
- Global enable: en = !m_valid || m_ready.
  - s_ready = en, combinational.
  - The window, stage 1 and the output register advance only when en is high.
- Latency: the result for centre (r,c) appears on m_valid in the 2nd cycle after input (r+1,c+1) is accepted, with no stalls. Throughput is 1 pixel/cycle.
- Stall: while m_valid && !m_ready, m_data and m_last hold, s_ready=0, and no state changes.
- A bubble on s_valid propagates as m_valid=0 two cycles later. There are no duplicates and no drops.
- Frame wrap is seamless. The first two rows of the next frame produce no outputs, even while the previous frame's last results drain.
- Reset values: m_valid=0, m_data=0, m_last=0, row=col=0, stage-1 valid=0. s_ready=1 in the cycle after reset.
- Reset mid-frame discards the partial frame and in-flight results. The next accepted pixel is (0,0). Stale line-buffer data is never used because rows 0–1 are gated.
- rst has priority over a simultaneous handshake.

## Configuration
- AMF_CENTER_PASS_EN:
  - Defined: if P5 is not noisy, m_data = P5 unchanged, so only noisy centres are replaced.
  - Undefined: every interior pixel is replaced by the stage-2 mean.
  - Latency and handshake are identical in both builds.

## Structure
- Package amf_pkg:
  - DW-derived constants: MAXV, SUM_W=DW+3, HV_W=DW+2, CNT_W=4.
  - Function is_noisy.
  - Typedef for the 3x3 window array.
- Sub-module amf_div8: combinational, exact floor(S/T) for S < 2^(DW+3) and T in 1..8. Output is DW bits; the result for T=0 is don't-care.
- Line buffers are inferred memories inside the top module.

## Test plan
- 5x5 frame, all pixels 100 -> exactly 9 outputs of 100; m_last only on the 9th.
- Window with P5=255 and neighbours P1..P9 minus P5 = 10,20,30,40,0,255,50,60 -> T=6, S=210, output 35 (also 35 with macro, since the centre is noisy).
- All neighbours noisy, with P2=0, P4=255, P6=255, P8=0 and corners 0/255 -> T=0, output (0+255+255+0)>>2 = 127.
- Ramp frame with m_ready held low for 5 cycles mid-frame:
  - m_data is held and s_ready=0 throughout.
  - The output sequence equals the model with no loss or duplication.
- rst pulsed after 7 accepted pixels of a frame:
  - m_valid=0 the next cycle.
  - A following full 5x5 frame yields exactly 9 correct outputs.
- Centre 77 with all neighbours 10:
  - With AMF_CENTER_PASS_EN defined -> 77.
  - Without it -> 10.
